vrom_arbiter: RTL



---
 rtl/vrom_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vrom_arbiter.sv
// vrom_arbiter: shares one synchronous video ROM between NUM_REQ read requesters.
// Requester 0 always wins. Requesters 1..NUM_REQ-1 share the ROM round-robin and
// may lock it for a burst of up to MAX_BURST consecutive grants. Each grant
// returns its ROM data one cycle later, tagged with the requester id.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | no burst held; every cycle is arbitrated normally
//   S_BURST | owner holds the ROM while req/lock stay high and cnt < MAX_BURST
module vrom_arbiter #(
    parameter  int NUM_REQ       = 4,
    parameter  int ADDRESS_WIDTH = 8,
    parameter  int DATA_WIDTH    = 8,
    parameter  int MAX_BURST     = 8,
    localparam int ID_W          = $clog2(NUM_REQ),
    localparam int CNT_W         = $clog2(MAX_BURST + 1)
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ-1:0]                 req_lock,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_addr,
    output logic [NUM_REQ-1:0]                 gnt,
    output logic [ADDRESS_WIDTH-1:0]           rom_addr,
    input  logic [DATA_WIDTH-1:0]              rom_data,
    output logic                               rd_valid,
    output logic [ID_W-1:0]                    rd_id,
    output logic [DATA_WIDTH-1:0]              rd_data
);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t           state, nxt_state;
    logic [ID_W-1:0]  owner, nxt_owner;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [ID_W-1:0]  ptr, nxt_ptr;

    logic             rr_found;
    logic [ID_W-1:0]  rr_win;
    logic             win_found;
    logic [ID_W-1:0]  win_id;

    // Round-robin search over 1..NUM_REQ-1, starting at ptr and wrapping to 1.
    always_comb begin
        logic [ID_W-1:0] idx;
        rr_found = 1'b0;
        rr_win   = '0;
        idx      = ptr;
        for (int j = 0; j < NUM_REQ - 1; j++) begin
            if (!rr_found && req[idx]) begin
                rr_found = 1'b1;
                rr_win   = idx;
            end
            idx = (idx == ID_W'(NUM_REQ - 1)) ? ID_W'(1) : idx + 1'b1;
        end
    end

    // Winner selection and next-state: req0 preempts, then burst hold, then round-robin.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        nxt_state = state;
        nxt_owner = owner;
        nxt_cnt   = cnt;
        nxt_ptr   = ptr;
        if (req[0]) begin
            win_found = 1'b1;
            win_id    = '0;
            nxt_state = S_IDLE;
            nxt_cnt   = '0;
        end else if (state == S_BURST && req[owner] && req_lock[owner] &&
                     cnt < CNT_W'(MAX_BURST)) begin
            win_found = 1'b1;
            win_id    = owner;
            nxt_cnt   = cnt + 1'b1;
        end else if (rr_found) begin
            win_found = 1'b1;
            win_id    = rr_win;
            // Moving past the winner makes it lowest priority next time round.
            nxt_ptr   = (rr_win == ID_W'(NUM_REQ - 1)) ? ID_W'(1) : rr_win + 1'b1;
            if (req_lock[rr_win]) begin
                nxt_state = S_BURST;
                nxt_owner = rr_win;
                nxt_cnt   = CNT_W'(1);
            end else begin
                nxt_state = S_IDLE;
                nxt_cnt   = '0;
            end
        end else begin
            nxt_state = S_IDLE;
            nxt_cnt   = '0;
        end
    end

    // Grant and ROM address are forced to zero while reset is asserted.
    always_comb begin
        gnt      = '0;
        rom_addr = '0;
        if (resetn && win_found) begin
            gnt[win_id] = 1'b1;
            rom_addr    = req_addr[win_id*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        end
    end

    assign rd_data = rom_data;

    // Arbiter state plus the read-return tag, captured on the same edge as the ROM address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            owner    <= '0;
            cnt      <= '0;
            ptr      <= ID_W'(1);
            rd_valid <= 1'b0;
            rd_id    <= '0;
        end else begin
            state    <= nxt_state;
            owner    <= nxt_owner;
            cnt      <= nxt_cnt;
            ptr      <= nxt_ptr;
            rd_valid <= win_found;
            rd_id    <= win_id;
        end
    end

endmodule
